// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param.
//   master: producer/consumer side (drives wr_en, data_in, rd_en; observes status and read data)
//   slave : FIFO side (observes requests; drives data_out, rd_valid, flags, count, error pulses)
interface sync_fifo_param_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
);
  logic                       wr_en;
  logic [WIDTH-1:0]           data_in;
  logic                       rd_en;
  logic [WIDTH-1:0]           data_out;
  logic                       rd_valid;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow,
           underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, rd_valid, full, empty, almost_full, almost_empty, count, overflow,
           underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost-full/almost-empty thresholds,
// overflow/underflow pulses and selectable standard or first-word-fall-through read.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - sync_fifo_param_if.slave: wr_en/data_in, rd_en, data_out/rd_valid, full, empty,
//          almost_full, almost_empty, count, overflow, underflow
module sync_fifo_param #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4,
  parameter bit          FWFT     = 1'b0
) (
  input logic              clk,
  input logic              rst,
  sync_fifo_param_if.slave bus
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [PtrW-1:0] LastPtr  = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfCnt    = CntW'(AF_LEVEL);
  localparam logic [CntW-1:0] AeCnt    = CntW'(AE_LEVEL);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, underflow_q;

  logic full, empty, wr_acc, rd_acc;

  // Flags come only from the count register, never from this cycle's requests.
  assign full   = (count_q == DepthCnt);
  assign empty  = (count_q == '0);
  assign wr_acc = bus.wr_en & ~full;
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Explicit wrap so any DEPTH works, not just powers of two.
    if (wr_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= bus.wr_en & full;
      underflow_q <= bus.rd_en & empty;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= bus.data_in;
  end

  if (FWFT) begin : g_fwft
    // Head word shown directly; meaningless while empty.
    assign bus.data_out = mem_q[rd_ptr_q];
    assign bus.rd_valid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] data_out_q;
    logic             rd_valid_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        data_out_q <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) data_out_q <= mem_q[rd_ptr_q];
      end
    end

    assign bus.data_out = data_out_q;
    assign bus.rd_valid = rd_valid_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfCnt);
  assign bus.almost_empty = (count_q <= AeCnt);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one standard-read and one FWFT instance share identical stimulus.
// A queue-based reference model predicts post-edge state; a monitor compares after each edge.
module tb_sync_fifo_param;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 5;
  localparam int unsigned AF = 4;
  localparam int unsigned AE = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus_std ();
  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus_ft ();

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_std)
  );

  sync_fifo_param #(
    .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)
  ) dut_ft (
    .clk(clk),
    .rst(rst),
    .bus(bus_ft)
  );

  typedef struct {
    int         cnt;
    bit         ovf;
    bit         unf;
    bit         rdv;
    logic [7:0] hold;
    bit         ft_v;
    logic [7:0] ft_head;
  } stat_t;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  stat_t      stat_q[$];
  logic [7:0] last_rd = 8'h00;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and record what the FIFO must look like after the edge.
  task automatic step(input bit r, input bit w, input bit rd, input logic [7:0] d);
    stat_t s;
    bit    was_full, was_empty, wacc, racc;
    @(negedge clk);
    rst = r;
    bus_std.wr_en = w;  bus_std.rd_en = rd;  bus_std.data_in = d;
    bus_ft.wr_en  = w;  bus_ft.rd_en  = rd;  bus_ft.data_in  = d;
    was_full  = (model_q.size() == D);
    was_empty = (model_q.size() == 0);
    s.ovf = 1'b0;
    s.unf = 1'b0;
    s.rdv = 1'b0;
    if (r) begin
      model_q.delete();
      last_rd = 8'h00;
    end else begin
      wacc  = w && !was_full;
      racc  = rd && !was_empty;
      s.ovf = w && was_full;
      s.unf = rd && was_empty;
      if (racc) begin
        last_rd = model_q.pop_front();
        exp_q.push_back(last_rd);
        s.rdv = 1'b1;
      end
      if (wacc) model_q.push_back(d);
    end
    s.cnt     = model_q.size();
    s.hold    = last_rd;
    s.ft_v    = (model_q.size() != 0);
    s.ft_head = s.ft_v ? model_q[0] : 8'h00;
    stat_q.push_back(s);
  endtask

  // Monitor: compares both instances against the predicted post-edge state.
  always @(posedge clk) begin
    stat_t      s;
    logic [7:0] e;
    #1;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      chk("count",        int'(bus_std.count),       s.cnt);
      chk("full",         int'(bus_std.full),        int'(s.cnt == D));
      chk("empty",        int'(bus_std.empty),       int'(s.cnt == 0));
      chk("almost_full",  int'(bus_std.almost_full), int'(s.cnt >= AF));
      chk("almost_empty", int'(bus_std.almost_empty), int'(s.cnt <= AE));
      chk("overflow",     int'(bus_std.overflow),    int'(s.ovf));
      chk("underflow",    int'(bus_std.underflow),   int'(s.unf));
      chk("rd_valid",     int'(bus_std.rd_valid),    int'(s.rdv));
      if (bus_std.rd_valid) begin
        if (exp_q.size() == 0) begin
          chk("read with no expected word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", int'(bus_std.data_out), int'(e));
        end
      end else begin
        chk("data_out hold", int'(bus_std.data_out), int'(s.hold));
      end
      chk("ft count",     int'(bus_ft.count),        s.cnt);
      chk("ft overflow",  int'(bus_ft.overflow),     int'(s.ovf));
      chk("ft underflow", int'(bus_ft.underflow),    int'(s.unf));
      chk("ft rd_valid",  int'(bus_ft.rd_valid),     int'(s.ft_v));
      if (s.ft_v) chk("ft data_out", int'(bus_ft.data_out), int'(s.ft_head));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit w, rd;
    int wr_pct, rd_pct;
    bus_std.wr_en = 1'b0;  bus_std.rd_en = 1'b0;  bus_std.data_in = '0;
    bus_ft.wr_en  = 1'b0;  bus_ft.rd_en  = 1'b0;  bus_ft.data_in  = '0;

    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Fill to full, then one overflowing write.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h11 + i));
    // Drain, then one underflowing read (data_out must hold 0x15).
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Pointer wrap: write 3 / read 3, four rounds.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + 3 * r + i));
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    end

    // Simultaneous traffic at count=2, then at full.
    step(1'b0, 1'b1, 1'b0, 8'h40);
    step(1'b0, 1'b1, 1'b0, 8'h41);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1, 8'(8'h42 + i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    step(1'b0, 1'b1, 1'b1, 8'h5f);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Empty, then single write followed by a pop (FWFT head visibility).
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'ha5);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset mid-operation with a write pending.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    step(1'b1, 1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Random traffic with drifting bias so both full and empty are visited often.
    for (int n = 0; n < 2000; n++) begin
      if ((n / 150) % 2 == 0) begin
        wr_pct = 70; rd_pct = 35;
      end else begin
        wr_pct = 35; rd_pct = 70;
      end
      w  = ($urandom_range(99) < wr_pct);
      rd = ($urandom_range(99) < rd_pct);
      step(($urandom_range(199) == 0), w, rd, 8'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #2;
    chk("read queue drained",   exp_q.size(),  0);
    chk("status queue drained", stat_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
